// File: rtl/pwm_duty_ctrl_if.sv
// Duty-request handshake between the control loop (master) and pwm_duty_ctrl (slave).
interface pwm_duty_ctrl_if;
  logic [10:0] duty_req;
  logic        req_vld;
  logic        req_rdy;

  modport master (output duty_req, output req_vld, input  req_rdy);
  modport slave  (input  duty_req, input  req_vld, output req_rdy);
endinterface

// File: rtl/pwm_duty_ctrl.sv
// PWM duty scheduler with period-aligned updates and a latched overcurrent trip.
// Optional macro SLEW_LIMIT_EN: ramp toward each request by at most SLEW_STEP per period.
module pwm_duty_ctrl #(
  parameter logic [10:0] SLEW_STEP = 11'd32,
  parameter logic [3:0]  OVR_LIMIT = 4'd3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  pwm_duty_ctrl_if.slave    req_if,
  input  logic              PWM_synch,
  input  logic              OVR_I_blank_n,
  input  logic              OVR_I,
  input  logic              flt_clr,
  output logic [10:0]       duty,
  output logic              pwm_en,
  output logic              fault,
  output logic [3:0]        ovr_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

  state_t      state_q, state_d;
  logic [10:0] duty_q, duty_d, target_q, target_d;
  logic        pending_q, pending_d, req_rdy_q, req_rdy_d;
  logic        pwm_en_q, pwm_en_d, fault_q, fault_d;
  logic        ovr_seen_q, ovr_seen_d;
  logic [3:0]  ovr_cnt_q, ovr_cnt_d;

  logic        accept, ovr_hit, ovr_any, trip, step_done;
  logic [4:0]  cnt_nxt;
  logic [10:0] step_duty;

  assign accept  = req_if.req_vld & req_rdy_q;
  assign ovr_hit = OVR_I & OVR_I_blank_n;
  assign ovr_any = ovr_seen_q | ovr_hit;
  assign cnt_nxt = ovr_any ? ({1'b0, ovr_cnt_q} + 5'd1) : 5'd0;
  assign trip    = PWM_synch & ovr_any & (cnt_nxt == {1'b0, OVR_LIMIT});

`ifdef SLEW_LIMIT_EN
  logic signed [11:0] diff;
  logic        [11:0] mag;

  // Signed 12-bit difference so a downward ramp never wraps through 2047.
  always_comb begin
    diff = $signed({1'b0, target_q}) - $signed({1'b0, duty_q});
    mag  = diff[11] ? 12'(-diff) : 12'(diff);
    if (mag <= {1'b0, SLEW_STEP}) begin
      step_duty = target_q;
      step_done = 1'b1;
    end else begin
      step_duty = diff[11] ? (duty_q - SLEW_STEP) : (duty_q + SLEW_STEP);
      step_done = 1'b0;
    end
  end
`else
  logic slew_unused;
  assign slew_unused = ^SLEW_STEP;
  assign step_duty   = target_q;
  assign step_done   = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    target_d   = target_q;
    pending_d  = pending_q;
    req_rdy_d  = req_rdy_q;
    pwm_en_d   = pwm_en_q;
    fault_d    = fault_q;
    ovr_seen_d = ovr_seen_q;
    ovr_cnt_d  = ovr_cnt_q;
    case (state_q)
      IDLE: begin
        if (en && PWM_synch) begin
          state_d   = RUN;
          pwm_en_d  = 1'b1;
          req_rdy_d = 1'b1;
        end
      end
      RUN: begin
        if (trip) begin
          state_d    = FAULT;
          duty_d     = '0;
          target_d   = '0;
          pending_d  = 1'b0;
          req_rdy_d  = 1'b0;
          pwm_en_d   = 1'b0;
          fault_d    = 1'b1;
          ovr_seen_d = 1'b0;
          ovr_cnt_d  = cnt_nxt[3:0];
        end else if (!en) begin
          state_d    = IDLE;
          duty_d     = '0;
          target_d   = '0;
          pending_d  = 1'b0;
          req_rdy_d  = 1'b0;
          pwm_en_d   = 1'b0;
          ovr_seen_d = 1'b0;
          ovr_cnt_d  = '0;
        end else begin
          if (PWM_synch) begin
            ovr_cnt_d  = cnt_nxt[3:0];
            ovr_seen_d = 1'b0;
            if (pending_q) begin
              duty_d    = step_duty;
              pending_d = ~step_done;
            end
          end else begin
            ovr_seen_d = ovr_any;
          end
          // A same-cycle accept latches the new target after the step used the old one.
          if (accept) begin
            target_d  = req_if.duty_req;
            pending_d = 1'b1;
          end
          req_rdy_d = ~pending_d;
          pwm_en_d  = 1'b1;
        end
      end
      FAULT: begin
        if (flt_clr) begin
          state_d   = IDLE;
          fault_d   = 1'b0;
          ovr_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      duty_q     <= '0;
      target_q   <= '0;
      pending_q  <= 1'b0;
      req_rdy_q  <= 1'b0;
      pwm_en_q   <= 1'b0;
      fault_q    <= 1'b0;
      ovr_seen_q <= 1'b0;
      ovr_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      target_q   <= target_d;
      pending_q  <= pending_d;
      req_rdy_q  <= req_rdy_d;
      pwm_en_q   <= pwm_en_d;
      fault_q    <= fault_d;
      ovr_seen_q <= ovr_seen_d;
      ovr_cnt_q  <= ovr_cnt_d;
    end
  end

  assign duty           = duty_q;
  assign pwm_en         = pwm_en_q;
  assign fault          = fault_q;
  assign ovr_cnt        = ovr_cnt_q;
  assign req_if.req_rdy = req_rdy_q;

endmodule

// File: doc/pwm_duty_ctrl.md
# pwm_duty_ctrl

Duty-cycle scheduler and overcurrent supervisor sitting between the balance/steering control loop and the 11-bit PWM generator. It accepts duty requests over a valid/ready handshake and applies them only on PWM period boundaries (PWM_synch). With slew limiting compiled in, it ramps toward each request by a bounded step per period. It also counts consecutive overcurrent periods during the unblanked window and latches a fault that shuts the bridge off until explicitly cleared.

## Interface
Parameters:
- SLEW_STEP, 11'd32, maximum duty change per PWM period (1..2047)
- OVR_LIMIT, 4'd3, consecutive overcurrent periods that trip FAULT (1..15)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high (one clock; reset is synchronous and active-high)
- en  in  1  run enable from top-level sequencer
- duty_req  in  11  requested duty, unsigned
- req_vld  in  1  duty_req valid
- req_rdy  out  1  block can accept a request
- PWM_synch  in  1  from PWM generator, high for the last count of each period
- OVR_I_blank_n  in  1  from PWM generator, high when current sensing is valid
- OVR_I  in  1  raw overcurrent comparator
- flt_clr  in  1  fault clear pulse
- duty  out  11  registered duty to PWM generator
- pwm_en  out  1  driver enable
- fault  out  1  latched overcurrent fault
- ovr_cnt  out  4  current consecutive-overcurrent period count

## Operation
- Reset (rst=1 at posedge): state=IDLE; duty=0, target=0, pending=0, pwm_en=0, fault=0, req_rdy=0, ovr_cnt=0, ovr_seen=0.
- States: IDLE, RUN, FAULT. Transition priority: rst > trip to FAULT > en deassert > normal operation.
- IDLE: duty=0, pwm_en=0. en=1 and PWM_synch=1 -> RUN, so the first period starts aligned.
- RUN: pwm_en=1 and req_rdy=~pending. Accept when req_vld&req_rdy: target<=duty_req, pending<=1.
- RUN, on PWM_synch with pending=1: diff=target-duty, computed at 12 bits signed. If |diff|<=SLEW_STEP, duty<=target and pending<=0. Otherwise duty<=duty±SLEW_STEP toward target. No wrap; duty stays within 0..2047.
- Accept and PWM_synch in the same cycle: the step uses the old target and the new target is latched. pending stays 1.
- Overcurrent: ovr_seen is set on any RUN cycle with OVR_I&OVR_I_blank_n. OVR_I is ignored while blanked.
- On PWM_synch: if (ovr_seen | (OVR_I&OVR_I_blank_n)), ovr_cnt<=ovr_cnt+1; else ovr_cnt<=0. ovr_seen is cleared on every synch.
- Trip: if the incremented count equals OVR_LIMIT -> FAULT. The trip overrides any duty step in that cycle.
- FAULT: duty=0, pwm_en=0, fault=1, req_rdy=0; target, pending and ovr_seen cleared; ovr_cnt holds the trip value.
- flt_clr=1 in FAULT -> IDLE with fault=0 and ovr_cnt=0. flt_clr is ignored in IDLE and RUN.
- en=0 in RUN -> IDLE on the next clock: duty=0, pending request discarded, ovr_cnt=0.

## Timing
- All outputs are registered. duty changes only on the cycle after a PWM_synch-high cycle, and never mid-period.
- req_rdy falls the cycle after acceptance and rises the cycle after the synch that completes the ramp.
- Request-to-duty latency: up to one PWM period (2048 clk with the 11-bit counter), plus ceil(|diff|/SLEW_STEP)-1 further periods.
- fault and pwm_en=0 appear the cycle after the tripping PWM_synch.
- rst mid-ramp or in FAULT returns to the full reset state in one cycle.

## Configuration
- SLEW_LIMIT_EN defined: ramping as above, step bounded by SLEW_STEP.
- SLEW_LIMIT_EN undefined: at the first PWM_synch with pending=1, duty<=target and pending<=0. SLEW_STEP is unused.

## Test plan
- Reset then en=1: no change until PWM_synch. On the cycle after synch: state RUN, pwm_en=1, req_rdy=1, duty=0.
- In RUN, request 11'd100 with SLEW_STEP=32 (SLEW_LIMIT_EN): duty goes 32, 64, 96, 100 on four successive synchs. req_rdy returns high after the 4th. Without the macro, duty=100 after the 1st synch.
- Overcurrent asserted only while OVR_I_blank_n=0 for 5 periods: ovr_cnt stays 0 and there is no fault.
- Overcurrent asserted while unblanked for 3 consecutive periods (OVR_LIMIT=3): ovr_cnt goes 1, 2, then fault=1, duty=0, pwm_en=0 after the 3rd synch. flt_clr then gives IDLE with fault=0.
- Overcurrent in 2 periods, a clean period, then 2 more: ovr_cnt goes 1, 2, 0, 1, 2 and there is no fault.
- Request accepted in the same cycle as PWM_synch mid-ramp (duty=64, old target 100, new 20): duty steps to 96, then ramps down to 64, 32, 20.
